// File: rtl/button_step_conditioner.sv
// rtl/button_step_conditioner.sv - synchronise and debounce the manual-step button into a one-cycle step pulse
module button_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       step_pulse,
  output logic       btn_level,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic             btn_sync;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic [7:0]       count_q, count_d;

  assign btn_sync = s2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  // The level and pulse registers change on the same edge as the state that owns them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (btn_sync) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        level_d = 1'b1;
        if (!btn_sync) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (btn_sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign step_pulse  = pulse_q;
  assign btn_level   = level_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_button_step_conditioner.sv
// tb/tb_button_step_conditioner.sv - randomized and directed checks of two debounce depths against a run-length model
module tb_button_step_conditioner;

  logic       clk;
  logic       reset;
  logic       btn;
  logic       p4, l4, p1, l1;
  logic [7:0] c4, c1;

  int n_checks = 0;
  int n_fail   = 0;

  button_step_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .btn_in(btn),
    .step_pulse(p4), .btn_level(l4), .press_count(c4)
  );

  button_step_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .reset(reset), .btn_in(btn),
    .step_pulse(p1), .btn_level(l1), .press_count(c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: the button level flips once D+1 consecutive synchronised samples
  // disagree with it; samples reach the decision two edges after btn_in is sampled.
  int hist[2][$];
  int mlv[2], mrun[2], mcnt[2], mpulse[2];
  int prev_p4, prev_p1;

  function automatic int dval(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      hist[i] = '{0, 0};
      mlv[i] = 0; mrun[i] = 0; mcnt[i] = 0; mpulse[i] = 0;
    end
    prev_p4 = 0;
    prev_p1 = 0;
  endtask

  task automatic model_step(input int b);
    for (int i = 0; i < 2; i++) begin
      int s;
      s = hist[i].pop_front();
      hist[i].push_back(b);
      mpulse[i] = 0;
      if (s != mlv[i]) begin
        mrun[i]++;
        if (mrun[i] == dval(i) + 1) begin
          mlv[i]  = s;
          mrun[i] = 0;
          if (s == 1) begin
            mpulse[i] = 1;
            mcnt[i]   = (mcnt[i] + 1) % 256;
          end
        end
      end else begin
        mrun[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(int'(btn));
    #1;
    check_eq("pulse4", int'(p4), mpulse[0]);
    check_eq("level4", int'(l4), mlv[0]);
    check_eq("count4", int'(c4), mcnt[0]);
    check_eq("pulse1", int'(p1), mpulse[1]);
    check_eq("level1", int'(l1), mlv[1]);
    check_eq("count1", int'(c1), mcnt[1]);
    check_eq("double4", prev_p4 & int'(p4), 0);
    check_eq("double1", prev_p1 & int'(p1), 0);
    prev_p4 = int'(p4);
    prev_p1 = int'(p1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_pulse4", int'(p4), 0);
    check_eq("rst_level4", int'(l4), 0);
    check_eq("rst_count4", int'(c4), 0);
    check_eq("rst_pulse1", int'(p1), 0);
    check_eq("rst_level1", int'(l1), 0);
    check_eq("rst_count1", int'(c1), 0);
    model_clear();
    #2;
    reset = 1'b1;
  endtask

  // Edge index 0 is the first edge sampling the new value.
  int fp4, fp1, np4, np1, fl4, fl1;

  task automatic run_btn(input logic v, input int n);
    btn = v;
    fp4 = -1; fp1 = -1; fl4 = -1; fl1 = -1; np4 = 0; np1 = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (p4) begin np4++; if (fp4 < 0) fp4 = i; end
      if (p1) begin np1++; if (fp1 < 0) fp1 = i; end
      if (l4 == v && fl4 < 0) fl4 = i;
      if (l1 == v && fl1 < 0) fl1 = i;
    end
  endtask

  initial begin
    int tot4, tot1, pc, sum4, len;
    reset = 1'b0;
    btn   = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Clean press then release
    run_btn(1'b1, 20);
    check_eq("clean_pulse_edge4", fp4, 6);
    check_eq("clean_level_edge4", fl4, 6);
    check_eq("clean_npulse4", np4, 1);
    check_eq("clean_count4", int'(c4), 1);
    check_eq("clean_pulse_edge1", fp1, 3);
    run_btn(1'b0, 10);
    check_eq("clean_release_edge4", fl4, 6);

    // Bounce on press
    do_reset();
    sum4 = 0;
    for (int k = 0; k < 2; k++) begin
      run_btn(1'b1, 2); sum4 += np4;
      run_btn(1'b0, 2); sum4 += np4;
    end
    check_eq("bounce_no_pulse4", sum4, 0);
    run_btn(1'b1, 20);
    check_eq("bounce_pulse_edge4", fp4, 6);
    check_eq("bounce_count4", int'(c4), 1);

    // Bounce on release while held
    run_btn(1'b0, 2);
    check_eq("relbounce_level4", fl4, -1);
    run_btn(1'b1, 6);
    check_eq("relbounce_npulse4", np4, 0);
    check_eq("relbounce_held4", int'(l4), 1);
    run_btn(1'b0, 10);
    check_eq("release_edge4", fl4, 6);

    // Reset during PRESS_CHK with cnt=2, button kept held
    do_reset();
    run_btn(1'b1, 5);
    check_eq("midrst_no_pulse4", np4, 0);
    do_reset();
    run_btn(1'b1, 10);
    check_eq("midrst_pulse_edge4", fp4, 6);
    check_eq("midrst_npulse4", np4, 1);

    // Single-cycle debounce depth
    do_reset();
    run_btn(1'b0, 3);
    run_btn(1'b1, 5);
    check_eq("d1_pulse_edge", fp1, 3);
    check_eq("d1_npulse", np1, 1);
    check_eq("d1_count", int'(c1), 1);

    // 257 presses: counter wrap and downstream 0..5 program counter
    do_reset();
    tot4 = 0; tot1 = 0; pc = 0;
    for (int k = 0; k < 257; k++) begin
      run_btn(1'b1, 8);
      tot4 += np4; tot1 += np1;
      pc = (pc + np4) % 6;
      run_btn(1'b0, 8);
      tot4 += np4; tot1 += np1;
      pc = (pc + np4) % 6;
    end
    check_eq("wrap_pulses4", tot4, 257);
    check_eq("wrap_pulses1", tot1, 257);
    check_eq("wrap_count4", int'(c4), 1);
    check_eq("wrap_count1", int'(c1), 1);
    check_eq("wrap_pc", pc, 5);

    // Random bouncing runs against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      len = $urandom_range(1, 9);
      run_btn(logic'($urandom_range(0, 1)), len);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_step_conditioner.md
Name: button_step_conditioner

Overview:
Conditions the raw manual-step push-button into a clean single-cycle step request. The output `step_pulse` drives the program counter's increment input (`control_input`) directly. The block synchronises the asynchronous button, rejects bounce with a stable-time counter, and emits exactly one pulse per accepted press. It also exposes the debounced level and a wrap-around press counter for board LEDs and debug.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a press or a release (10 ms at 100 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 20, width of the internal stability counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_in  input  1  raw push-button, asynchronous to clk, active-high, may bounce.
- step_pulse  output  1  one-cycle-high pulse per accepted press; connects to the PC's increment control.
- btn_level  output  1  debounced button level.
- press_count  output  8  number of accepted presses, modulo 256.

Behaviour:
- Reset (reset=0, asynchronous), all cleared:
  - synchroniser flops s1 and s2 = 0
  - state = IDLE, stability counter cnt = 0
  - step_pulse = 0, btn_level = 0, press_count = 0
- Synchroniser: btn_in -> s1 -> s2. Only s2 (btn_sync) feeds logic; btn_in is never used combinationally.
- FSM, evaluated on each rising clk edge:
  - IDLE (btn_level=0): if btn_sync=1, go to PRESS_CHK with cnt<=0.
  - PRESS_CHK (btn_level=0):
    - if btn_sync=0, go to IDLE and clear cnt (bounce rejected, no pulse);
    - else if cnt==DEBOUNCE_CYCLES-1, go to HELD, set step_pulse<=1, increment press_count;
    - else cnt<=cnt+1.
  - HELD (btn_level=1): step_pulse<=0. If btn_sync=0, go to RELEASE_CHK with cnt<=0.
  - RELEASE_CHK (btn_level=1):
    - if btn_sync=1, return to HELD and clear cnt, with no new pulse;
    - else if cnt==DEBOUNCE_CYCLES-1, go to IDLE (btn_level becomes 0);
    - else cnt<=cnt+1.
- Latency: let E0 be the first edge at which s1 samples btn_in=1, with btn_in held stable afterwards.
  - btn_sync=1 after E1; PRESS_CHK entered at E2.
  - step_pulse rises at edge E(DEBOUNCE_CYCLES+2) and falls at the following edge.
  - btn_level rises at the same edge as step_pulse.
  - Release is symmetric: btn_level falls at edge E(DEBOUNCE_CYCLES+2) relative to the first edge sampling btn_in=0.
- All outputs are registered. step_pulse is never high for two consecutive cycles.
- Holding the button indefinitely produces exactly one pulse; there is no auto-repeat.
- A new pulse requires a full accepted release (return to IDLE) followed by a full accepted press.
- press_count increments only on step_pulse and wraps 255 -> 0.
- DEBOUNCE_CYCLES=1: PRESS_CHK and RELEASE_CHK last exactly one cycle each. This is legal and must work.
- Pulses on btn_in shorter than one clk period may be missed. This is acceptable and is not a defect.
- Reset asserted mid-operation (any state):
  - outputs clear immediately;
  - a pulse in flight is cancelled;
  - after reset deasserts, a button still held is treated as a fresh press (full debounce, then one pulse).

Test Plan:
- DEBOUNCE_CYCLES=4, clean press: btn_in 0->1 held 20 cycles.
  - Required: exactly one step_pulse, 6 edges after the first sampling edge.
  - Required: btn_level=1 from the same edge; press_count=1.
- Bounce: btn_in toggles 1,0,1,0 with 2-cycle high periods, then holds 1.
  - Required: no pulse during toggling; one pulse 6 edges after the final rise; press_count=1.
- Release bounce: while HELD, drop btn_in for 2 cycles, then restore.
  - Required: btn_level stays 1 and no second pulse.
  - Then release for 10 cycles: btn_level=0 at +6 edges.
- Repeated presses: 257 clean press/release cycles.
  - Required: press_count=1 at the end (wrap); 257 single-cycle pulses.
  - Downstream PC model (0..5 wrap) reads 257 mod 6 = 5.
- Reset mid-press: assert reset during PRESS_CHK with cnt=2.
  - Required: outputs immediately 0 and no pulse.
  - Deassert reset with the button held: one pulse 6 edges after the first sampling edge post-reset.
- DEBOUNCE_CYCLES=1: single press held 5 cycles.
  - Required: step_pulse at edge E3, high for exactly 1 cycle; press_count=1.
